// File: rtl/instr_register_param.sv
// rtl/instr_register_param.sv - instruction slot file with addressed and FIFO access
// Each slot stores an instruction plus its precomputed result; read data is staged one extra edge.
module instr_register_param #(
  parameter int DEPTH    = 32,
  parameter int OP_WIDTH = 32,
  localparam int RW = 2 * OP_WIDTH,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       load_en,
  input  logic                       rd_en,
  input  logic                       fifo_mode,
  input  logic [3:0]                 opcode,
  input  logic signed [OP_WIDTH-1:0] operand_a,
  input  logic signed [OP_WIDTH-1:0] operand_b,
  input  logic [AW-1:0]              write_pointer,
  input  logic [AW-1:0]              read_pointer,
  output logic [3:0]                 rd_opcode,
  output logic [OP_WIDTH-1:0]        rd_operand_a,
  output logic [OP_WIDTH-1:0]        rd_operand_b,
  output logic signed [RW-1:0]       rd_result,
  output logic                       rd_err,
  output logic                       rd_valid,
  output logic [AW:0]                count,
  output logic                       full,
  output logic                       empty,
  output logic                       overflow,
  output logic                       underflow
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef struct packed {
    logic [3:0]          op;
    logic [OP_WIDTH-1:0] a;
    logic [OP_WIDTH-1:0] b;
    logic [RW-1:0]       res;
    logic                err;
  } slot_t;

  slot_t                slot_q [DEPTH];
  slot_t                slot_d;
  slot_t                rd_slot_q, rd_slot_d;
  slot_t                out_q, out_d;

  logic signed [RW-1:0] a_x, b_x, alu_res;
  logic                 alu_err;

  logic [AW-1:0]        head_q, head_d, head_cur;
  logic [AW-1:0]        tail_q, tail_d, tail_cur;
  logic [AW:0]          count_q, count_d, count_cur;
  logic                 mode_q, mode_d;
  logic                 rd_pend_q, rd_pend_d;
  logic                 rd_valid_q, rd_valid_d;
  logic                 overflow_q, overflow_d;
  logic                 underflow_q, underflow_d;
  logic                 wr_fire, rd_fire;
  logic [AW-1:0]        wr_addr, rd_addr;

  // Operands are widened first so MULT and the MIN/-1 divide cannot overflow.
  always_comb begin
    a_x     = {{OP_WIDTH{operand_a[OP_WIDTH-1]}}, operand_a};
    b_x     = {{OP_WIDTH{operand_b[OP_WIDTH-1]}}, operand_b};
    alu_res = '0;
    alu_err = 1'b0;
    case (opcode)
      4'd0: alu_res = '0;
      4'd1: alu_res = a_x;
      4'd2: alu_res = b_x;
      4'd3: alu_res = a_x + b_x;
      4'd4: alu_res = a_x - b_x;
      4'd5: alu_res = a_x * b_x;
      4'd6: begin
        if (operand_b == '0) alu_err = 1'b1;
        else                 alu_res = a_x / b_x;
      end
      4'd7: begin
        if (operand_b == '0) alu_err = 1'b1;
        else                 alu_res = a_x % b_x;
      end
      default: alu_err = 1'b1;
    endcase
    slot_d = '{op: opcode, a: operand_a, b: operand_b, res: alu_res, err: alu_err};
  end

  // A mode change this edge restarts the queue; the cycle's own request then sees it empty.
  always_comb begin
    mode_d      = fifo_mode;
    head_cur    = (fifo_mode != mode_q) ? '0 : head_q;
    tail_cur    = (fifo_mode != mode_q) ? '0 : tail_q;
    count_cur   = (fifo_mode != mode_q) ? '0 : count_q;
    head_d      = head_cur;
    tail_d      = tail_cur;
    count_d     = count_cur;
    overflow_d  = 1'b0;
    underflow_d = 1'b0;
    wr_addr     = write_pointer;
    rd_addr     = read_pointer;
    wr_fire     = 1'b0;
    rd_fire     = 1'b0;
    if (!fifo_mode) begin
      wr_fire = load_en;
      rd_fire = rd_en;
    end else begin
      wr_addr     = tail_cur;
      rd_addr     = head_cur;
      rd_fire     = rd_en && (count_cur != '0);
      wr_fire     = load_en && ((count_cur != FULL_CNT) || rd_fire);
      underflow_d = rd_en && (count_cur == '0);
      overflow_d  = load_en && !wr_fire;
      if (rd_fire) head_d = head_cur + AW'(1);
      if (wr_fire) tail_d = tail_cur + AW'(1);
      case ({wr_fire, rd_fire})
        2'b10:   count_d = count_cur + (AW+1)'(1);
        2'b01:   count_d = count_cur - (AW+1)'(1);
        default: count_d = count_cur;
      endcase
    end
    rd_pend_d  = rd_fire;
    rd_slot_d  = rd_fire ? slot_q[rd_addr] : rd_slot_q;
    rd_valid_d = rd_pend_q;
    out_d      = rd_pend_q ? rd_slot_q : out_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) slot_q[i] <= '0;
      rd_slot_q   <= '0;
      out_q       <= '0;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      mode_q      <= 1'b0;
      rd_pend_q   <= 1'b0;
      rd_valid_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (wr_fire) slot_q[wr_addr] <= slot_d;
      rd_slot_q   <= rd_slot_d;
      out_q       <= out_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      mode_q      <= mode_d;
      rd_pend_q   <= rd_pend_d;
      rd_valid_q  <= rd_valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign rd_opcode    = out_q.op;
  assign rd_operand_a = out_q.a;
  assign rd_operand_b = out_q.b;
  assign rd_result    = out_q.res;
  assign rd_err       = out_q.err;
  assign rd_valid     = rd_valid_q;
  assign count        = count_q;
  assign full         = (count_q == FULL_CNT);
  assign empty        = (count_q == '0);
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

endmodule

// File: doc/instr_register_param.md
INSTR_REGISTER_PARAM -- requirements
Module: instr_register_param

Interface
REQ-001 SHALL have parameter DEPTH, default 32: number of instruction slots; power of two, 2 to 256.
REQ-002 SHALL have parameter OP_WIDTH, default 32: signed operand width; result width RW = 2*OP_WIDTH; AW = $clog2(DEPTH).
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port load_en  input  1  write request for {opcode, operand_a, operand_b}.
REQ-006 SHALL have port rd_en  input  1  read request.
REQ-007 SHALL have port fifo_mode  input  1  0 = addressed mode, 1 = FIFO mode.
REQ-008 SHALL have port opcode  input  4  operation code, encoded per REQ-019.
REQ-009 SHALL have ports operand_a, operand_b  input  OP_WIDTH  signed operands.
REQ-010 SHALL have ports write_pointer, read_pointer  input  AW  slot addresses; used in addressed mode only.
REQ-011 SHALL have ports rd_opcode (4), rd_operand_a (OP_WIDTH), rd_operand_b (OP_WIDTH), rd_result (RW, signed), rd_err (1)  output  read data.
REQ-012 SHALL have port rd_valid  output  1  read data valid.
REQ-013 SHALL have ports count  output  AW+1, full  output  1, and empty  output  1  FIFO occupancy.
REQ-014 SHALL have ports overflow  output  1 and underflow  output  1  single-cycle error pulses.

Function
REQ-015 Each slot SHALL hold {opcode, operand_a, operand_b, result, err}; result and err are computed combinationally from the inputs and stored in the same write cycle.
REQ-016 In addressed mode, load_en SHALL write slot[write_pointer]; rd_en SHALL read slot[read_pointer]; a read and a write to the same slot in one cycle SHALL return the old contents.
REQ-017 Read latency SHALL be 1 cycle: rd_en sampled at edge N drives rd_* and rd_valid=1 after edge N+1. Without a read, rd_valid SHALL be 0 and rd_* SHALL hold their last values.
REQ-018 In FIFO mode, writes SHALL go to the tail and reads SHALL come from the head; both pointers wrap from DEPTH-1 to 0. count = entries, full = (count==DEPTH), empty = (count==0).
REQ-019 Opcodes: 0 ZERO->0; 1 PASSA->a; 2 PASSB->b; 3 ADD->a+b; 4 SUB->a-b; 5 MULT->a*b (full signed product); 6 DIV->a/b, truncated toward zero; 7 MOD->a%b, sign of dividend. All values sign-extended to RW.
REQ-020 DIV or MOD with b==0, and opcodes 8-15, SHALL store result=0 and err=1; otherwise err=0.
REQ-021 FIFO write when full with no read in the same cycle SHALL be dropped and pulse overflow for 1 cycle. Write when full with a read in the same cycle SHALL be accepted, and count SHALL stay DEPTH.
REQ-022 FIFO read when empty SHALL give rd_valid=0 and pulse underflow for 1 cycle. A simultaneous write SHALL still be accepted, giving count=1; there is no write-through.
REQ-023 A simultaneous accepted read and write SHALL leave count unchanged.
REQ-024 A change of fifo_mode between consecutive edges SHALL clear the head, tail and count. Slot contents SHALL be retained.
REQ-025 In addressed mode, count, full and empty SHALL hold their values, and overflow and underflow SHALL stay 0.

Reset
REQ-026 Asserting reset SHALL immediately clear all slots to 0 (opcode ZERO, err 0), the head, the tail, count, all rd_* outputs, rd_valid, overflow and underflow. It SHALL set empty=1 and full=0.
REQ-027 Reset asserted mid-operation SHALL abandon any pending read. The first write or read SHALL be accepted at the first rising edge after reset deasserts.

Verification
REQ-028 Addressed mode, DEPTH=32, OP_WIDTH=32: write ADD a=5, b=-3 to slot 7, then read slot 7 -> one cycle later rd_valid=1, rd_result=2, rd_err=0.
REQ-029 Write MULT a=-2147483648, b=-2147483648 -> rd_result=0x4000_0000_0000_0000. Write DIV a=-7, b=2 -> rd_result=-3. Write MOD a=-7, b=2 -> rd_result=-1.
REQ-030 Write DIV a=9, b=0, and opcode 12 -> both read back with rd_result=0 and rd_err=1.
REQ-031 FIFO mode, DEPTH=4: perform 5 writes -> full=1 after the 4th, overflow pulses on the 5th, count=4. Then 4 reads return entries in write order. A 5th read gives rd_valid=0, an underflow pulse, and empty=1.
REQ-032 FIFO mode, full: simultaneous read and write -> count stays 4, and the pointers wrap correctly over 3 further cycles.
REQ-033 Assert reset between a read request and its data return -> rd_valid stays 0 and all outputs are 0. The first write after deassertion is stored.
